pc_fetch_ctrl: RTL and testbench

Parametrised program-counter and fetch-request controller, successor to the single-register PC with its +4/target mux. It owns the PC register and issues instruction-fetch requests to imem over a valid/ready handshake. It selects the next PC by priority: trap, then branch/jump redirect, then a deferred redirect, then sequential. It also tags requests with an epoch bit so downstream logic can discard wrong-path fetches.

---
 rtl/pc_fetch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program-counter owner and imem fetch-request issuer. Next PC priority is
// trap > redirect > deferred redirect > pc+4; an epoch bit marks each new path.
module pc_fetch_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_target,
    input  logic             req_ready,
    output logic             req_valid,
    output logic [XLEN-1:0]  req_addr,
    output logic             req_epoch,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             misalign,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] fetch_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [XLEN-1:0]  r_pc;
    logic             r_epoch;
    logic             r_pend;
    logic [XLEN-1:0]  r_pend_tgt;
    logic             r_pend_trap;
    logic             r_misalign;
    logic [XLEN-1:0]  r_misalign_addr;
    logic [CNT_W-1:0] r_count;

    state_t           w_state_nxt;
    logic [XLEN-1:0]  w_pc_nxt;
    logic             w_epoch_nxt;
    logic             w_pend_nxt;
    logic [XLEN-1:0]  w_pend_tgt_nxt;
    logic             w_pend_trap_nxt;
    logic             w_mis_nxt;
    logic [XLEN-1:0]  w_mis_addr_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    logic             w_trap_ok;
    logic             w_trap_bad;
    logic             w_redir_ok;
    logic             w_redir_bad;
    logic             w_nonseq;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_sel;

    // A good trap drops any simultaneous redirect, so that redirect is never checked.
    assign w_trap_ok   = trap_valid && (trap_target[1:0] == 2'b00);
    assign w_trap_bad  = trap_valid && (trap_target[1:0] != 2'b00);
    assign w_redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00) && !w_trap_ok;
    assign w_redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00) && !w_trap_ok;
    assign w_nonseq    = w_trap_ok || w_redir_ok || r_pend;
    assign w_pc_plus4  = r_pc + XLEN'(4);
    assign w_sel       = w_trap_ok  ? trap_target     :
                         w_redir_ok ? redirect_target :
                         r_pend     ? r_pend_tgt      : w_pc_plus4;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_epoch_nxt     = r_epoch;
        w_pend_nxt      = r_pend;
        w_pend_tgt_nxt  = r_pend_tgt;
        w_pend_trap_nxt = r_pend_trap;
        w_mis_nxt       = 1'b0;
        w_mis_addr_nxt  = r_misalign_addr;
        w_count_nxt     = r_count;

        if (r_state != ST_IDLE) begin
            if (w_trap_bad) begin
                w_mis_nxt      = 1'b1;
                w_mis_addr_nxt = trap_target;
            end else if (w_redir_bad) begin
                w_mis_nxt      = 1'b1;
                w_mis_addr_nxt = redirect_target;
            end
        end

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = stall ? ST_HOLD : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (req_ready) begin
                    w_pc_nxt        = w_sel;
                    w_count_nxt     = r_count + CNT_W'(1);
                    w_epoch_nxt     = r_epoch ^ w_nonseq;
                    w_pend_nxt      = 1'b0;
                    w_pend_trap_nxt = 1'b0;
                    w_state_nxt     = stall ? ST_HOLD : ST_ISSUE;
                end else if (w_trap_ok) begin
                    w_pend_nxt      = 1'b1;
                    w_pend_tgt_nxt  = trap_target;
                    w_pend_trap_nxt = 1'b1;
                end else if (w_redir_ok && !(r_pend && r_pend_trap)) begin
                    w_pend_nxt      = 1'b1;
                    w_pend_tgt_nxt  = redirect_target;
                    w_pend_trap_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (w_trap_ok || w_redir_ok) begin
                    w_pc_nxt    = w_trap_ok ? trap_target : redirect_target;
                    w_epoch_nxt = ~r_epoch;
                end
                if (!stall) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_pc            <= RESET_VECTOR;
            r_epoch         <= 1'b0;
            r_pend          <= 1'b0;
            r_pend_tgt      <= '0;
            r_pend_trap     <= 1'b0;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
            r_count         <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_epoch         <= w_epoch_nxt;
            r_pend          <= w_pend_nxt;
            r_pend_tgt      <= w_pend_tgt_nxt;
            r_pend_trap     <= w_pend_trap_nxt;
            r_misalign      <= w_mis_nxt;
            r_misalign_addr <= w_mis_addr_nxt;
            r_count         <= w_count_nxt;
        end
    end

    // Valid/ready: req_valid, once high, keeps req_addr/req_epoch stable until
    // the cycle with req_valid && req_ready; stall never withdraws it.
    assign req_valid     = (r_state == ST_ISSUE);
    assign req_addr      = r_pc;
    assign req_epoch     = r_epoch;
    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign misalign      = r_misalign;
    assign misalign_addr = r_misalign_addr;
    assign fetch_count   = r_count;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model of PC, epoch, deferred redirect and counters.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        req_ready;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_epoch;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [15:0] fetch_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic        m_fresh;
  logic        m_req;
  logic [31:0] m_pc;
  logic        m_epoch;
  logic        m_pend;
  logic [31:0] m_pend_tgt;
  logic        m_pend_trap;
  logic        m_mis;
  logic [31:0] m_mis_addr;
  logic [15:0] m_cnt;

  pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(RV), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .req_ready(req_ready), .req_valid(req_valid), .req_addr(req_addr),
    .req_epoch(req_epoch), .pc(pc), .pc_plus4(pc_plus4),
    .misalign(misalign), .misalign_addr(misalign_addr),
    .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: one call per rising edge, from the inputs seen at that edge.
  task automatic model_step();
    logic t_ok, r_ok, redirected;
    logic [31:0] nxt;
    if (!reset) begin
      m_fresh = 1'b1; m_req = 1'b0; m_pc = RV; m_epoch = 1'b0;
      m_pend = 1'b0; m_pend_tgt = '0; m_pend_trap = 1'b0;
      m_mis = 1'b0; m_mis_addr = '0; m_cnt = '0;
      return;
    end
    t_ok = trap_valid && (trap_target % 4 == 0);
    r_ok = redirect_valid && (redirect_target % 4 == 0) && !t_ok;
    m_mis = 1'b0;
    if (!m_fresh) begin
      if (trap_valid && !t_ok) begin
        m_mis = 1'b1; m_mis_addr = trap_target;
      end else if (redirect_valid && !t_ok && (redirect_target % 4 != 0)) begin
        m_mis = 1'b1; m_mis_addr = redirect_target;
      end
    end
    if (m_fresh) begin
      m_fresh = 1'b0;
      m_req = !stall;
    end else if (m_req && req_ready) begin
      redirected = t_ok || r_ok || m_pend;
      if (t_ok) nxt = trap_target;
      else if (r_ok) nxt = redirect_target;
      else if (m_pend) nxt = m_pend_tgt;
      else nxt = m_pc + 32'd4;
      if (redirected) m_epoch = !m_epoch;
      m_pc = nxt;
      m_pend = 1'b0;
      m_pend_trap = 1'b0;
      m_cnt = m_cnt + 16'd1;
      m_req = !stall;
    end else if (m_req) begin
      if (t_ok) begin
        m_pend = 1'b1; m_pend_tgt = trap_target; m_pend_trap = 1'b1;
      end else if (r_ok && !(m_pend && m_pend_trap)) begin
        m_pend = 1'b1; m_pend_tgt = redirect_target; m_pend_trap = 1'b0;
      end
    end else begin
      if (t_ok) begin
        m_pc = trap_target; m_epoch = !m_epoch;
      end else if (r_ok) begin
        m_pc = redirect_target; m_epoch = !m_epoch;
      end
      m_req = !stall;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    stall = 1'b0; req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = '0;
    trap_valid = 1'b0; trap_target = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(0, 5))
      0: t[1:0] = 2'($urandom_range(1, 3));
      1: t = 32'hFFFF_FFF0 | {28'd0, t[3:2], 2'b00};
      default: t[1:0] = 2'b00;
    endcase
    return t;
  endfunction

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    tick(); tick();
    n_checks++; if (req_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", req_valid); else n_pass++;
    n_checks++; if (pc !== RV) $display("FAIL rst_pc: got %h expected %h", pc, RV); else n_pass++;
    n_checks++; if (fetch_count !== 16'd0) $display("FAIL rst_count: got %0d expected 0", fetch_count); else n_pass++;
    n_checks++; if (req_epoch !== 1'b0) $display("FAIL rst_epoch: got %b expected 0", req_epoch); else n_pass++;
    n_checks++; if ({misalign, misalign_addr} !== 33'd0) $display("FAIL rst_misalign: got %b/%h expected 0/0", misalign, misalign_addr); else n_pass++;
    reset = 1'b1;
    n_checks++; if (req_valid !== 1'b0) $display("FAIL idle_valid: got %b expected 0", req_valid); else n_pass++;
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_q[$];
    exp_q = '{32'h100, 32'h104, 32'h108};
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (req_valid !== 1'b1 || req_addr !== exp_q[i]) $display("FAIL seq_addr%0d: got %b/%h expected 1/%h", i, req_valid, req_addr, exp_q[i]); else n_pass++;
      n_checks++; if (fetch_count !== 16'(i) || req_epoch !== 1'b0) $display("FAIL seq_cnt%0d: got %0d/%b expected %0d/0", i, fetch_count, req_epoch, i); else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect_accept();
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (req_addr !== 32'h200 || req_epoch !== 1'b1) $display("FAIL redir_acc: got %h/%b expected 200/1", req_addr, req_epoch); else n_pass++;
  endtask

  task automatic test_deferred();
    do_reset();
    tick(); tick();
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (req_valid !== 1'b1 || req_addr !== 32'h108 || req_epoch !== 1'b0) $display("FAIL defer_hold1: got %b/%h/%b expected 1/108/0", req_valid, req_addr, req_epoch); else n_pass++;
    tick();
    req_ready = 1'b1;
    n_checks++; if (req_valid !== 1'b1 || req_addr !== 32'h108 || req_epoch !== 1'b0) $display("FAIL defer_hold2: got %b/%h/%b expected 1/108/0", req_valid, req_addr, req_epoch); else n_pass++;
    tick();
    n_checks++; if (req_addr !== 32'h300 || req_epoch !== 1'b1) $display("FAIL defer_load: got %h/%b expected 300/1", req_addr, req_epoch); else n_pass++;
  endtask

  task automatic test_priority_misalign();
    do_reset();
    trap_valid = 1'b1; trap_target = 32'h400;
    redirect_valid = 1'b1; redirect_target = 32'h500;
    tick();
    trap_valid = 1'b0;
    n_checks++; if (req_addr !== 32'h400 || req_epoch !== 1'b1 || misalign !== 1'b0) $display("FAIL prio_trap: got %h/%b/%b expected 400/1/0", req_addr, req_epoch, misalign); else n_pass++;
    redirect_target = 32'h502;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (misalign !== 1'b1 || misalign_addr !== 32'h502) $display("FAIL mis_pulse: got %b/%h expected 1/502", misalign, misalign_addr); else n_pass++;
    n_checks++; if (req_addr !== 32'h404 || req_epoch !== 1'b1) $display("FAIL mis_seq: got %h/%b expected 404/1", req_addr, req_epoch); else n_pass++;
    tick();
    n_checks++; if (misalign !== 1'b0 || misalign_addr !== 32'h502 || req_addr !== 32'h408) $display("FAIL mis_end: got %b/%h/%h expected 0/502/408", misalign, misalign_addr, req_addr); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h10;
    tick();
    redirect_valid = 1'b0; stall = 1'b1;
    tick();
    n_checks++; if (req_valid !== 1'b0 || pc !== 32'h14 || fetch_count !== 16'd2) $display("FAIL stall_hold: got %b/%h/%0d expected 0/14/2", req_valid, pc, fetch_count); else n_pass++;
    tick();
    n_checks++; if (req_valid !== 1'b0 || pc !== 32'h14) $display("FAIL stall_noinc: got %b/%h expected 0/14", req_valid, pc); else n_pass++;
    redirect_valid = 1'b1; redirect_target = 32'h600;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    n_checks++; if (req_valid !== 1'b0 || pc !== 32'h600 || req_epoch !== 1'b0) $display("FAIL hold_redir: got %b/%h/%b expected 0/600/0", req_valid, pc, req_epoch); else n_pass++;
    tick();
    n_checks++; if (req_valid !== 1'b1 || req_addr !== 32'h600) $display("FAIL stall_release: got %b/%h expected 1/600", req_valid, req_addr); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (req_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) $display("FAIL wrap_top: got %h/%h expected fffffffc/0", req_addr, pc_plus4); else n_pass++;
    tick();
    n_checks++; if (req_addr !== 32'h0 || req_epoch !== 1'b1 || misalign !== 1'b0) $display("FAIL wrap_zero: got %h/%b/%b expected 0/1/0", req_addr, req_epoch, misalign); else n_pass++;
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h700;
    tick();
    redirect_valid = 1'b0;
    reset = 1'b0;
    tick();
    n_checks++; if (req_valid !== 1'b0 || pc !== RV || req_epoch !== 1'b0 || fetch_count !== 16'd0) $display("FAIL midrst: got %b/%h/%b/%0d expected 0/%h/0/0", req_valid, pc, req_epoch, fetch_count, RV); else n_pass++;
    reset = 1'b1;
    tick();
    req_ready = 1'b1;
    tick();
    n_checks++; if (req_addr !== 32'h104 || req_epoch !== 1'b0) $display("FAIL midrst_nopend: got %h/%b expected 104/0", req_addr, req_epoch); else n_pass++;
  endtask

  task automatic test_random();
    logic        was_waiting;
    logic [31:0] held_addr;
    logic        held_epoch;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      reset           = ($urandom_range(0, 79) != 0);
      stall           = ($urandom_range(0, 3) == 0);
      req_ready       = ($urandom_range(0, 2) != 0);
      trap_valid      = ($urandom_range(0, 9) == 0);
      trap_target     = rand_target();
      redirect_valid  = ($urandom_range(0, 4) == 0);
      redirect_target = rand_target();
      was_waiting = req_valid && !req_ready && reset;
      held_addr   = req_addr;
      held_epoch  = req_epoch;
      tick();
      if (was_waiting) begin
        n_checks++; if (req_valid !== 1'b1 || req_addr !== held_addr || req_epoch !== held_epoch) $display("FAIL rnd_stable@%0d: got %b/%h/%b expected 1/%h/%b", i, req_valid, req_addr, req_epoch, held_addr, held_epoch); else n_pass++;
      end
      n_checks++; if (req_valid !== m_req || req_addr !== m_pc || pc !== m_pc || req_epoch !== m_epoch) $display("FAIL rnd_req@%0d: got %b/%h/%b expected %b/%h/%b", i, req_valid, req_addr, req_epoch, m_req, m_pc, m_epoch); else n_pass++;
      n_checks++; if (pc_plus4 !== m_pc + 32'd4) $display("FAIL rnd_plus4@%0d: got %h expected %h", i, pc_plus4, m_pc + 32'd4); else n_pass++;
      n_checks++; if (misalign !== m_mis || misalign_addr !== m_mis_addr) $display("FAIL rnd_mis@%0d: got %b/%h expected %b/%h", i, misalign, misalign_addr, m_mis, m_mis_addr); else n_pass++;
      n_checks++; if (fetch_count !== m_cnt) $display("FAIL rnd_cnt@%0d: got %0d expected %0d", i, fetch_count, m_cnt); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_redirect_accept();
    test_deferred();
    test_priority_misalign();
    test_stall();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
